crypto_mmio_unit: RTL
=====================

// Module: crypto_mmio_unit
// PURPOSE
//  Memory-mapped cipher coprocessor on the CPU data bus (selected by address decode, e.g. addr[9]).
//  Holds key, plaintext and ciphertext registers; the key comes from a TRNG capture or a CPU write.
//  Runs a ROUNDS-round rotate/XOR cipher with a busy/done handshake and an optional interrupt.
// PARAMETERS
//  DATA_W  10  cipher block and key width in bits (2..32)
//  ROUNDS  4   rounds per operation (1..16); latency in cycles
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  reset      in   1       asynchronous, active-high; clears all state
//  sel        in   1       chip select from bus decode
//  we         in   1       write strobe (qualified by sel)
//  addr       in   4       byte offset: 0x0 CTRL, 0x4 PT, 0x8 CT, 0xC KEY
//  wdata      in   32      write data
//  rdata      out  32      read data, combinational, zero-extended; 0 when !sel
//  trng_data  in   DATA_W  TRNG output word
//  trng_ready in   1       1-cycle TRNG valid pulse
//  irq        out  1       done & irq_en
// BEHAVIOUR
//  Reset: key=pt=ct=0, key_valid=done=err=busy=irq_en=cap_arm=0, FSM=IDLE, rdata=0, irq=0.
//  CTRL write: b0 start, b1 arm TRNG capture, b3 clear done/err, b4 irq_en (level, stored).
//  CTRL read: b0 busy, b1 done, b2 key_valid, b3 err, b4 irq_en, b5 cap_arm.
//  PT (0x4): R/W, low DATA_W bits. CT (0x8): read-only; writes ignored. KEY (0xC): R/W.
//  Key source: KEY write sets key and key_valid=1. If cap_arm and trng_ready: key<=trng_data,
//   key_valid=1, cap_arm=0. KEY write and trng_ready in the same cycle: CPU write wins, cap_arm stays 1.
//  While busy: KEY writes ignored; trng_ready is not consumed, so cap_arm stays set and the next
//   pulse after busy drops is taken. PT writes are accepted and do not affect the running operation.
//  FSM IDLE -> RUN -> DONE:
//   IDLE: start with key_valid=1 -> s<=pt, k<=key, i<=0, done=0, err=0, RUN.
//         start with key_valid=0 -> err=1, stay IDLE.
//   RUN: each cycle s <= rotl1(s ^ rotl(k,i)) mod 2^DATA_W; rotl(k,i) rotates left by i mod DATA_W.
//        On i==ROUNDS-1, ct <= new s; go DONE. Otherwise i++.
//   DONE: done=1 (sticky), busy=0. Start here behaves as from IDLE. CTRL b3 -> IDLE, done=0.
//  busy=1 for exactly ROUNDS cycles: the start write is at edge N, ct is valid and done=1 after edge N+ROUNDS.
//  Start while busy: ignored, no err. Start and b3 in the same write: start wins and done is cleared.
//  Reset mid-operation aborts immediately: ct=0, no done, no irq.
// CONFIGURATION
//  CRYPTO_DECRYPT_EN defined: CTRL b2 (write) = decrypt mode, latched at start and readable at CTRL b6.
//   Decrypt runs i = ROUNDS-1 down to 0 with s <= rotr1(s) ^ rotl(k,i), giving the exact inverse.
//   Same latency and handshake as encrypt.
//  Not defined: CTRL b2 write ignored, b6 reads 0; encrypt only.
// TESTING (DATA_W=10, ROUNDS=4)
//  1. KEY=0x000, PT=0x001, start -> busy 4 cycles, then CT=0x010, done=1, CTRL read = 0x06.
//  2. KEY=0x3FF, PT=0x000, start -> CT=0x000 after 4 cycles; irq=1 iff irq_en=1; b3 write -> irq=0.
//  3. After reset, start without a key -> err=1, busy stays 0, CT=0; KEY write then start -> normal run.
//  4. Arm capture, trng_ready pulse with trng_data=0x2AA -> KEY=0x2AA, key_valid=1, cap_arm=0;
//     a second pulse leaves KEY unchanged.
//  5. Mid-run: PT write, KEY write, start and trng_ready (capture armed) -> CT matches the original
//     inputs; the armed capture fires on the first pulse after done.
//  6. Assert reset at RUN cycle 2 -> all registers 0, no done; with CRYPTO_DECRYPT_EN, decrypt of
//     test 1's CT returns 0x001.

Source files
------------

// File: rtl/crypto_mmio_unit.sv
// Memory-mapped rotate/XOR cipher coprocessor with TRNG key capture and done interrupt.
// Optional decrypt mode is compiled in when CRYPTO_DECRYPT_EN is defined.
module crypto_mmio_unit #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned ROUNDS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              we,
  input  logic [3:0]        addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [DATA_W-1:0] trng_data,
  input  logic              trng_ready,
  output logic              irq
);

  localparam int unsigned IW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [IW-1:0] LAST_RND = IW'(ROUNDS - 1);

  localparam logic [3:0] ADDR_CTRL = 4'h0;
  localparam logic [3:0] ADDR_PT   = 4'h4;
  localparam logic [3:0] ADDR_CT   = 4'h8;
  localparam logic [3:0] ADDR_KEY  = 4'hC;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] key_q, key_d, pt_q, pt_d, ct_q, ct_d;
  logic [DATA_W-1:0] s_q, s_d, k_q, k_d;
  logic [IW-1:0]     i_q, i_d;
  logic              key_valid_q, key_valid_d, done_q, done_d, err_q, err_d;
  logic              irq_en_q, irq_en_d, cap_arm_q, cap_arm_d;

  logic              wr, ctrl_wr, start_req, busy, start_dec, last;
  logic [DATA_W-1:0] rk, s_next;

`ifdef CRYPTO_DECRYPT_EN
  logic dec_q, dec_d;
  assign start_dec = wdata[2];
`else
  logic dec_q;
  assign dec_q     = 1'b0;
  assign start_dec = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x, input int unsigned n);
    logic [2*DATA_W-1:0] t;
    t = {x, x} << (n % DATA_W);
    return t[2*DATA_W-1:DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] x);
    return {x[DATA_W-2:0], x[DATA_W-1]};
  endfunction

  function automatic logic [DATA_W-1:0] rotr1(input logic [DATA_W-1:0] x);
    return {x[0], x[DATA_W-1:1]};
  endfunction

  assign wr        = sel & we;
  assign ctrl_wr   = wr && (addr == ADDR_CTRL);
  assign start_req = ctrl_wr && wdata[0];
  assign busy      = (state_q == StRun);
  assign irq       = done_q & irq_en_q;

  // Decrypt walks the round index downwards, so the final round is index 0.
  assign rk     = rotl(k_q, 32'(i_q));
  assign s_next = dec_q ? (rotr1(s_q) ^ rk) : rotl1(s_q ^ rk);
  assign last   = dec_q ? (i_q == '0) : (i_q == LAST_RND);

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    pt_d        = pt_q;
    ct_d        = ct_q;
    s_d         = s_q;
    k_d         = k_q;
    i_d         = i_q;
    key_valid_d = key_valid_q;
    done_d      = done_q;
    err_d       = err_q;
    irq_en_d    = irq_en_q;
    cap_arm_d   = cap_arm_q;
`ifdef CRYPTO_DECRYPT_EN
    dec_d       = dec_q;
`endif

    if (wr && addr == ADDR_PT) pt_d = wdata[DATA_W-1:0];

    // A CPU key write beats a simultaneous capture and leaves the capture armed.
    if (wr && addr == ADDR_KEY && !busy) begin
      key_d       = wdata[DATA_W-1:0];
      key_valid_d = 1'b1;
    end else if (cap_arm_q && trng_ready && !busy) begin
      key_d       = trng_data;
      key_valid_d = 1'b1;
      cap_arm_d   = 1'b0;
    end

    if (ctrl_wr) begin
      irq_en_d = wdata[4];
      if (wdata[1]) cap_arm_d = 1'b1;
      if (wdata[3]) begin
        done_d = 1'b0;
        err_d  = 1'b0;
        if (state_q == StDone) state_d = StIdle;
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start_req) begin
          if (key_valid_q) begin
            s_d     = pt_q;
            k_d     = key_q;
            i_d     = start_dec ? LAST_RND : '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            state_d = StRun;
`ifdef CRYPTO_DECRYPT_EN
            dec_d   = wdata[2];
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        s_d = s_next;
        if (last) begin
          ct_d    = s_next;
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          i_d = dec_q ? (i_q - 1'b1) : (i_q + 1'b1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      key_q       <= '0;
      pt_q        <= '0;
      ct_q        <= '0;
      s_q         <= '0;
      k_q         <= '0;
      i_q         <= '0;
      key_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      irq_en_q    <= 1'b0;
      cap_arm_q   <= 1'b0;
`ifdef CRYPTO_DECRYPT_EN
      dec_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      pt_q        <= pt_d;
      ct_q        <= ct_d;
      s_q         <= s_d;
      k_q         <= k_d;
      i_q         <= i_d;
      key_valid_q <= key_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      irq_en_q    <= irq_en_d;
      cap_arm_q   <= cap_arm_d;
`ifdef CRYPTO_DECRYPT_EN
      dec_q       <= dec_d;
`endif
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        ADDR_CTRL: begin
          rdata[0] = busy;
          rdata[1] = done_q;
          rdata[2] = key_valid_q;
          rdata[3] = err_q;
          rdata[4] = irq_en_q;
          rdata[5] = cap_arm_q;
          rdata[6] = dec_q;
        end
        ADDR_PT:  rdata[DATA_W-1:0] = pt_q;
        ADDR_CT:  rdata[DATA_W-1:0] = ct_q;
        ADDR_KEY: rdata[DATA_W-1:0] = key_q;
        default:  rdata = '0;
      endcase
    end
  end

  // Upper write-data bits (and unused CTRL bits) are intentionally ignored.
  logic unused_wdata;
  assign unused_wdata = ^wdata;

endmodule
